// File: rtl/vmem_pkg.sv
// Shared constants and types for the vector memory responder.
// Geometry: 512 words of 32 bits, moved 16 words (512 bits) per request.
package vmem_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 16;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 10;
  localparam int VEC_W  = WORD_W * LANES;
  localparam int BEAT_W = $clog2(LANES);
  localparam int RAM_AW = $clog2(DEPTH);

  // DEPTH expressed at request-address width and at beat-address width.
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);

  typedef enum logic {OP_LOAD, OP_STORE} vmem_op_t;
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP} vmem_state_t;
  typedef logic signed [WORD_W-1:0] word_t;

endpackage

// File: rtl/vmem_ram.sv
// Word array with one asynchronous read port and one synchronous write port.
// Contents are never reset; they survive a responder reset.
module vmem_ram
  import vmem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  word_t             wdata,
  input  logic [RAM_AW-1:0] raddr,
  output word_t             rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vec_mem_responder.sv
// Vector load/store responder: accepts a request, moves one word per beat
// for 16 beats, then holds a 512-bit response until it is accepted.
module vec_mem_responder
  import vmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VEC_W-1:0]  req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [VEC_W-1:0]  resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  vmem_state_t       state_reg;
  logic [BEAT_W-1:0] beat_reg;
  vmem_op_t          op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [VEC_W-1:0]  wdata_reg;
  word_t             acc_reg [LANES];
  logic              req_ready_reg;
  logic              resp_valid_reg;
  logic              resp_err_reg;
  logic              busy_reg;

  word_t             wword [LANES];
  logic [ADDR_W:0]   addr_eff;
  logic              beat_ok;
  logic              ram_we;
  word_t             ram_rdata;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign wword[gi] = wdata_reg[gi*WORD_W +: WORD_W];
      assign resp_rdata[gi*WORD_W +: WORD_W] = acc_reg[gi];
    end
  endgenerate

  // One bit wider than the request address so base + beat never overflows.
  assign addr_eff = {1'b0, addr_reg} + (ADDR_W + 1)'(beat_reg);
  assign beat_ok  = addr_eff < DEPTH_X;
  // Decoded from the async-reset state so a reset mid-store stops writes at once.
  assign ram_we   = (state_reg == S_XFER) && (op_reg == OP_STORE) && beat_ok;

  vmem_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (addr_eff[RAM_AW-1:0]),
    .wdata (wword[beat_reg]),
    .raddr (addr_eff[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      beat_reg       <= '0;
      op_reg         <= OP_LOAD;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid && req_ready_reg) begin
            op_reg        <= vmem_op_t'(req_op);
            addr_reg      <= req_addr;
            wdata_reg     <= req_wdata;
            beat_reg      <= '0;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
              acc_reg[i] <= '0;
            end
            // Out-of-range base: answer with an error, never touch memory.
            if (req_addr >= DEPTH_A) begin
              resp_err_reg   <= 1'b1;
              resp_valid_reg <= 1'b1;
              state_reg      <= S_RESP;
            end else begin
              state_reg <= S_XFER;
            end
          end
        end
        S_XFER: begin
          if (op_reg == OP_LOAD && beat_ok) begin
            acc_reg[beat_reg] <= ram_rdata;
          end
          beat_reg <= beat_reg + BEAT_W'(1);
          if (beat_reg == LAST_BEAT) begin
            resp_valid_reg <= 1'b1;
            state_reg      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            req_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_vec_mem_responder.sv
// Scoreboard bench for vec_mem_responder: expectations are queued when a
// request is driven and popped when its response appears.
module tb_vec_mem_responder;
  import vmem_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [VEC_W-1:0]  req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [VEC_W-1:0]  resp_rdata;
  logic              resp_err;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [VEC_W-1:0] rdata;
    logic             err;
    int               lat;
  } exp_t;

  exp_t sb[$];
  logic [WORD_W-1:0] model [DEPTH];

  always #5 clk = ~clk;

  vec_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  function automatic logic [VEC_W-1:0] pattern(input logic [WORD_W-1:0] base, input int step);
    logic [VEC_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WORD_W +: WORD_W] = base + WORD_W'(i * step);
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] model_load(input int addr);
    logic [VEC_W-1:0] v = '0;
    for (int i = 0; i < LANES; i++)
      if (addr + i < DEPTH) v[i*WORD_W +: WORD_W] = model[addr + i];
    return v;
  endfunction

  // Scoreboard push: expected response plus the memory effect of the request.
  task automatic expect_req(input logic op, input int addr, input logic [VEC_W-1:0] wd);
    exp_t e;
    e.err   = (addr >= DEPTH);
    e.lat   = e.err ? 1 : 17;
    e.rdata = (!op && !e.err) ? model_load(addr) : '0;
    if (op && !e.err)
      for (int i = 0; i < LANES; i++)
        if (addr + i < DEPTH) model[addr + i] = wd[i*WORD_W +: WORD_W];
    sb.push_back(e);
  endtask

  // Drives one request and collects its response; lat counts cycles from accept.
  task automatic run_req(input logic op, input int addr, input logic [VEC_W-1:0] wd,
                         output logic [VEC_W-1:0] rd, output logic er, output int lat);
    int n = 0;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = ADDR_W'(addr);
    req_wdata  = wd;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    if (resp_valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors += 2;
    if ({req_ready, resp_valid, resp_err, busy} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 1000", {req_ready, resp_valid, resp_err, busy});
    end
    if (resp_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata got %h want 0", resp_rdata);
    end
    $display("reset: ctrl=%b", {req_ready, resp_valid, resp_err, busy});
    @(negedge clk) rst = 1'b0;
  endtask

  // Shared body for table-driven request sequences; compares rdata, err, latency inline.
  task automatic test_seq(input string tag, input int n, input logic ops[8], input int addrs[8],
                          input logic [VEC_W-1:0] wds[8]);
    exp_t e;
    logic [VEC_W-1:0] rd;
    logic er;
    int lat;
    for (int k = 0; k < n; k++) begin
      expect_req(ops[k], addrs[k], wds[k]);
      run_req(ops[k], addrs[k], wds[k], rd, er, lat);
      e = sb.pop_front();
      vectors += 3;
      if (rd !== e.rdata) begin
        miscompares++;
        $display("FAIL %s_rdata[%0d] got %h want %h", tag, k, rd, e.rdata);
      end
      if (er !== e.err) begin
        miscompares++;
        $display("FAIL %s_err[%0d] got %b want %b", tag, k, er, e.err);
      end
      if (lat != e.lat) begin
        miscompares++;
        $display("FAIL %s_lat[%0d] got %0d want %0d", tag, k, lat, e.lat);
      end
      $display("%s[%0d]: op=%0d addr=%0d err=%b lat=%0d", tag, k, ops[k], addrs[k], er, lat);
    end
  endtask

  task automatic test_round_trip;
    logic ops[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int addrs[8] = '{5, 5, 0, 0, 0, 0, 0, 0};
    logic [VEC_W-1:0] wds[8];
    wds[0] = pattern(32'h1000_0000, 1);
    for (int i = 1; i < 8; i++) wds[i] = '0;
    test_seq("round_trip", 2, ops, addrs, wds);
  endtask

  task automatic test_top_boundary;
    logic ops[8] = '{1, 0, 1, 1, 0, 0, 0, 0};
    int addrs[8] = '{496, 500, 0, 508, 496, 0, 0, 0};
    logic [VEC_W-1:0] wds[8];
    for (int i = 0; i < 8; i++) wds[i] = '0;
    wds[0] = pattern(32'd496, 1);
    wds[2] = pattern(32'h0000_00A0, 1);
    wds[3] = pattern(32'hFFFF_FFFF, 0);
    test_seq("boundary", 6, ops, addrs, wds);
  endtask

  task automatic test_invalid;
    logic ops[8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    int addrs[8] = '{600, 1023, 496, 0, 0, 0, 0, 0};
    logic [VEC_W-1:0] wds[8];
    for (int i = 0; i < 8; i++) wds[i] = '0;
    wds[1] = pattern(32'hDEAD_0000, 1);
    test_seq("invalid", 4, ops, addrs, wds);
  endtask

  task automatic test_backpressure;
    exp_t e;
    int n = 0;
    int lat;
    expect_req(1'b0, 0, '0);
    expect_req(1'b0, 496, '0);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 1'b0; req_addr = '0; req_wdata = '0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_addr = ADDR_W'(496);  // second request held pending while busy
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    vectors += 2;
    if (lat != e.lat) begin
      miscompares++;
      $display("FAIL bp_lat got %0d want %0d", lat, e.lat);
    end
    if (resp_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL bp_rdata got %h want %h", resp_rdata, e.rdata);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vectors += 2;
      if ({resp_valid, req_ready, busy, resp_err} !== 4'b1010) begin
        miscompares++;
        $display("FAIL bp_hold_ctrl[%0d] got %b want 1010", c, {resp_valid, req_ready, busy, resp_err});
      end
      if (resp_rdata !== e.rdata) begin
        miscompares++;
        $display("FAIL bp_hold_rdata[%0d] got %h want %h", c, resp_rdata, e.rdata);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({resp_valid, req_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL bp_complete got %b want 010", {resp_valid, req_ready, busy});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if ({req_ready, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_second_accept got %b want 01", {req_ready, busy});
    end
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    vectors += 2;
    if (lat != e.lat) begin
      miscompares++;
      $display("FAIL bp2_lat got %0d want %0d", lat, e.lat);
    end
    if (resp_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL bp2_rdata got %h want %h", resp_rdata, e.rdata);
    end
    $display("backpressure: second response lat=%0d", lat);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_store;
    logic [VEC_W-1:0] nd = pattern(32'hB000_0000, 1);
    int n = 0;
    int seen = 0;
    logic ops[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int addrs[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic [VEC_W-1:0] wds[8];
    for (int i = 0; i < 8; i++) wds[i] = '0;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = 1'b1; req_addr = '0; req_wdata = nd;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;  // beats 0..6 commit on these edges
    end
    rst = 1'b1;
    #1;
    vectors += 2;
    if ({req_ready, resp_valid, resp_err, busy} !== 4'b1000) begin
      miscompares++;
      $display("FAIL mid_rst_ctrl got %b want 1000", {req_ready, resp_valid, resp_err, busy});
    end
    if (resp_rdata !== '0) begin
      miscompares++;
      $display("FAIL mid_rst_rdata got %h want 0", resp_rdata);
    end
    for (int i = 0; i < 7; i++) model[i] = nd[i*WORD_W +: WORD_W];
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL mid_rst_no_resp got %0d valid cycles want 0", seen);
    end
    $display("reset_mid_store: stray response cycles=%0d", seen);
    test_seq("after_rst", 1, ops, addrs, wds);
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_top_boundary();
    test_invalid();
    test_backpressure();
    test_reset_mid_store();
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vec_mem_responder.md
Name: vec_mem_responder

Overview:
- Memory-side responder for the processor's 512-bit vector load/store traffic.
- Owns a 512 x 32-bit signed word array.
- Accepts one request at a time over a valid/ready handshake and moves one 32-bit word per cycle, 16 words per request.
- Returns a 512-bit response over a second valid/ready handshake, so the processor no longer touches memory directly.

Parameters:
WORD_W, 32, bits per memory word
LANES, 16, words per vector (vector width = WORD_W*LANES = 512)
DEPTH, 512, number of memory words
ADDR_W, 10, request address width (can express addresses beyond DEPTH-1)

Ports:
clk  input  1  clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_op  input  1  0 = load, 1 = store
req_addr  input  ADDR_W  base word address (entry1 equivalent)
req_wdata  input  WORD_W*LANES  store data; word i is bits [32i +: 32]
resp_valid  output  1  response present
resp_ready  input  1  requester accepts the response
resp_rdata  output  WORD_W*LANES  load data; word i = mem[addr+i]
resp_err  output  1  request rejected (addr >= DEPTH)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1) forces:
  - State = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, busy = 0.
  - Beat counter = 0.
  - Memory array contents are NOT reset.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch op, addr and wdata.
  - If addr >= DEPTH: go to RESP with resp_err = 1 and resp_rdata = 0. No memory access; resp_valid is high the next cycle.
  - Otherwise: clear the data accumulator, beat = 0, go to XFER.
- XFER:
  - req_ready = 0. Lasts exactly LANES cycles (beat 0..15). Each beat addresses word a = addr + beat.
  - Load: if a <= DEPTH-1, accumulator word[beat] = mem[a] (combinational array read, captured at the edge); else word[beat] stays 0.
  - Store: if a <= DEPTH-1, mem[a] = wdata word[beat]; else no write. No wrap-around to mem[0].
  - After beat 15, go to RESP. For a store, resp_rdata = 0 and resp_err = 0.
- Latency: accept edge at cycle 0, beats on cycles 1..16, resp_valid high from cycle 17. Error responses: resp_valid high at cycle 1.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are stable while resp_ready = 0.
  - On resp_valid & resp_ready, go to IDLE. req_ready rises the following cycle; no accept occurs in the same cycle as response completion.
- Address arithmetic: addr + beat is computed at ADDR_W+1 bits so a cannot overflow.
- A request arriving while busy is not accepted; req_valid must be held until req_ready.
- Reset mid-XFER:
  - Words already stored remain written; no further writes occur.
  - A load is discarded and no response is produced.
- Read-after-write: a load accepted after a store response sees all of that store's words.

Decomposition:
- Package vmem_pkg:
  - Constants WORD_W, LANES, DEPTH, ADDR_W, VEC_W = WORD_W*LANES.
  - typedef enum logic {OP_LOAD, OP_STORE} vmem_op_t.
  - typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP} vmem_state_t.
  - typedef logic signed [WORD_W-1:0] word_t.
- Sub-module vmem_ram:
  - DEPTH x WORD_W array with one asynchronous read port and one synchronous write port (we, waddr, wdata).
  - Contains no reset.
- vec_mem_responder holds the FSM, beat counter, request latches and accumulator.

Test Plan:
- Round trip: store base 5, word i = 32'h1000_0000 + i, then load base 5 -> resp_rdata word i = 32'h1000_0000 + i. resp_valid on cycle 17 after each accept; resp_err = 0.
- Top boundary load: preload mem[j] = j, load base 500 -> words 0..11 = 500..511, words 12..15 = 0.
- Top boundary store: store base 508 with all words 32'hFFFF_FFFF -> mem[508..511] = FFFF_FFFF; mem[0..3] unchanged (no wrap); resp_err = 0.
- Invalid address: load base 600 -> resp_valid at cycle 1, resp_err = 1, resp_rdata = 0; store base 1023 -> no memory word changes.
- Backpressure: hold resp_ready = 0 for 5 cycles in RESP -> resp_valid/resp_rdata stable, req_ready = 0, a second request is not accepted until the cycle after the response completes.
- Reset mid-store: assert rst during beat 7 of a store at base 0 -> mem[0..6] = new data, mem[7..15] unchanged, outputs at reset values immediately (async), no response issued.
